dcp_rd_cmd_arb: RTL and testbench
=================================

Name: dcp_rd_cmd_arb

Overview:
Weighted round-robin arbiter that shares one read-command crossbar input lane between N requesters. It merges N Decoupled read-command streams (Vld/Rdy/Pld/Dst) into one registered output stream that feeds a crossbar switch-unit input. Each requester may hold the lane for up to a per-requester quota of consecutive beats, which limits head-of-line stealing between ports.

Parameters:
N, 16, number of requesters (power of two, ≥2)
DW, `ADDR_LENTH+9, payload width (crossbar command width)
AW, 4, destination index width
QW, 4, per-requester quota field width

Ports:
iClk  in  1  clock; the single clock of the block
iRst  in  1  reset, synchronous, active-high; sampled only on the iClk rising edge
iVld  in  N  per-requester command valid
iPld  in  N*DW  per-requester payload, requester k at [k*DW +: DW]
iDst  in  N*AW  per-requester destination, requester k at [k*AW +: AW]
oRdy  out  N  per-requester ready (combinational)
iQuota  in  N*QW  per-requester beat quota, static config; a value of 0 is treated as 1
oVld  out  1  merged command valid (registered)
oPld  out  DW  merged payload (registered)
oDst  out  AW  merged destination (registered)
oSrc  out  log2(N)  index of the requester that produced the current output beat (registered)
iRdy  in  1  downstream ready
oBusy  out  1  high while the FSM is in LOCK

Behaviour:
- Reset (iRst=1 at an iClk edge): state=IDLE, ptr=0, owner=0, cnt=0, quota latch=0. oVld, oPld, oDst and oSrc all clear to 0. oBusy=0.
- While iRst=1, oRdy is 0 on every bit. Reset mid-LOCK abandons the lock. An output beat held at that moment is dropped.
- Output stage:
  - One-entry register. canAcc = !oVld || iRdy.
  - A beat accepted from requester k in cycle t appears on oVld/oPld/oDst/oSrc in cycle t+1. Latency is 1.
  - Throughput is 1 beat per cycle when iRdy=1.
  - While oVld && !iRdy, oPld/oDst/oSrc hold stable and every oRdy bit is 0.
  - If there is no accept and iRdy=1, oVld clears.
- Handshake: a beat transfers from requester k when iVld[k] && oRdy[k]. At most one oRdy bit is high per cycle. oRdy[k] never depends on iVld of any other requester except through the arbitration pick.
- Pick: w = the first k with iVld[k]=1, searching ptr, ptr+1, ... modulo N (wrap from N-1 to 0).
- FSM state IDLE:
  - If any iVld and canAcc: oRdy[w]=1 and the beat is accepted.
  - Latch q = max(iQuota[w], 1) and owner=w.
  - If q==1: ptr = w+1 mod N and stay in IDLE.
  - Otherwise: cnt=1 and go to LOCK.
  - If no iVld, or !canAcc: nothing changes.
- FSM state LOCK:
  - Only the owner is eligible.
  - If iVld[owner] && canAcc: accept the beat and cnt=cnt+1. If cnt+1==q: ptr = owner+1 mod N, go to IDLE.
  - If !iVld[owner] (owner gap): release with no beat, ptr = owner+1 mod N, go to IDLE. Arbitration resumes next cycle, giving one bubble.
  - If iVld[owner] && !canAcc: hold the state.
- Quota changes take effect only at the next grant; the value latched at grant time is used for the whole lock.
- cnt is QW+1 bits wide, so quota 2^QW-1 never overflows.
- Simultaneous iRdy=1 and a new accept: the output register reloads in the same cycle with no bubble.

Decomposition:
- Shared package dcp_arb_pkg holds:
  - the state enum {IDLE, LOCK};
  - the default N, AW and QW constants;
  - the CRSBAR_WIDTH constant (`ADDR_LENTH+9`).
- One sub-module, dcp_rr_pick: combinational rotate-priority picker. Inputs are req[N] and ptr; outputs are gnt one-hot and idx.
- FSM, counters and the output register live in dcp_rd_cmd_arb.

Test Plan:
1. Reset, then only iVld[3]=1, iQuota all 1, iRdy=1, iPld=0x1A5 → the next cycle gives oVld=1, oSrc=3, oPld=0x1A5. ptr becomes 4.
2. All 16 iVld held high, quota all 1, iRdy=1 → oSrc sequence 0,1,2,...,15,0 with one beat per cycle and no bubbles.
3. iVld[2] and iVld[5] high, iQuota[2]=3, iQuota[5]=3, all others 1 → oSrc sequence 2,2,2,5,5,5,2,... oBusy=1 during the locked beats.
4. Full traffic with iRdy=0 for 4 cycles → oPld/oSrc stay constant, all oRdy=0, and no beat is lost or duplicated. The scoreboard per-source counts match.
5. Requester 7 has quota 4 and drops iVld after 2 beats while requester 9 is valid → release, one idle cycle, then oSrc=9.
6. iRst asserted for one cycle in LOCK (owner 5, cnt=2) → the next cycle has oVld=0, oBusy=0, and the first grant after reset goes to the lowest valid index searching from 0.

Source files
------------

// File: rtl/dcp_arb_pkg.sv
// dcp_arb_pkg: shared types and default sizing for the read-command lane arbiter.
`ifndef ADDR_LENTH
`define ADDR_LENTH 32
`endif
package dcp_arb_pkg;
    typedef enum logic {IDLE, LOCK} state_e;
    localparam int ARB_N = 16;
    localparam int ARB_AW = 4;
    localparam int ARB_QW = 4;
    localparam int CRSBAR_WIDTH = `ADDR_LENTH + 9;
endpackage

// File: rtl/dcp_rd_cmd_arb_if.sv
// dcp_rd_cmd_arb_if: requester-side and lane-side signals of the read-command arbiter.
interface dcp_rd_cmd_arb_if #(
    parameter int N  = dcp_arb_pkg::ARB_N,
    parameter int DW = dcp_arb_pkg::CRSBAR_WIDTH,
    parameter int AW = dcp_arb_pkg::ARB_AW,
    parameter int QW = dcp_arb_pkg::ARB_QW
) ();
    logic [N-1:0] iVld;
    logic [N*DW-1:0] iPld;
    logic [N*AW-1:0] iDst;
    logic [N-1:0] oRdy;
    logic [N*QW-1:0] iQuota;
    logic oVld;
    logic [DW-1:0] oPld;
    logic [AW-1:0] oDst;
    logic [$clog2(N)-1:0] oSrc;
    logic iRdy;
    logic oBusy;
    modport slave (input iVld, iPld, iDst, iQuota, iRdy, output oRdy, oVld, oPld, oDst, oSrc, oBusy);
    modport master (output iVld, iPld, iDst, iQuota, iRdy, input oRdy, oVld, oPld, oDst, oSrc, oBusy);
endinterface

// File: rtl/dcp_rr_pick.sv
// dcp_rr_pick: first requester at or after ptr, wrapping modulo N.
module dcp_rr_pick #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    always_comb begin
        logic [IW-1:0] j;
        idx = ptr;
        j = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            j = ptr + IW'(i);
            if (req[j]) idx = j;
        end
        gnt = |req ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/dcp_rd_cmd_arb.sv
// dcp_rd_cmd_arb: weighted round-robin merge of N read-command streams onto one registered lane.
module dcp_rd_cmd_arb
    import dcp_arb_pkg::*;
#(
    parameter int N  = ARB_N,
    parameter int DW = CRSBAR_WIDTH,
    parameter int AW = ARB_AW,
    parameter int QW = ARB_QW
) (
    input logic iClk,
    input logic iRst,
    dcp_rd_cmd_arb_if.slave bus
);
    localparam int IW = $clog2(N);
    state_e state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, src_q, src_d, idx, sel;
    logic [QW:0] cnt_q, cnt_d, cnt_nx;
    logic [QW-1:0] quota_q, quota_d, quota_raw, quota_new;
    logic [DW-1:0] pld_q, pld_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [N-1:0] gnt, rdy;
    logic vld_q, vld_d, can_acc, own_vld, acc;

    dcp_rr_pick #(.N(N)) u_pick (.req(bus.iVld), .ptr(ptr_q), .gnt(gnt), .idx(idx));

    assign can_acc = !vld_q || bus.iRdy;
    assign own_vld = bus.iVld[owner_q];
    assign sel = state_q == LOCK ? owner_q : idx;
    assign rdy = (iRst || !can_acc) ? '0 : state_q == LOCK ? (own_vld ? N'(1) << owner_q : '0) : gnt;
    assign acc = |rdy;
    assign quota_raw = bus.iQuota[idx*QW +: QW];
    assign quota_new = quota_raw == '0 ? QW'(1) : quota_raw;
    assign cnt_nx = cnt_q + (QW+1)'(1);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            owner_q <= '0;
            cnt_q <= '0;
            quota_q <= '0;
            vld_q <= 1'b0;
            pld_q <= '0;
            dst_q <= '0;
            src_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            owner_q <= owner_d;
            cnt_q <= cnt_d;
            quota_q <= quota_d;
            vld_q <= vld_d;
            pld_q <= pld_d;
            dst_q <= dst_d;
            src_q <= src_d;
        end
    end

    // An owner gap releases the lock even when the output stage is stalled.
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        owner_d = owner_q;
        cnt_d = cnt_q;
        quota_d = quota_q;
        if (state_q == IDLE) begin
            if (acc) begin
                owner_d = idx;
                quota_d = quota_new;
                cnt_d = (QW+1)'(1);
                state_d = quota_new == QW'(1) ? IDLE : LOCK;
                ptr_d = quota_new == QW'(1) ? idx + IW'(1) : ptr_q;
            end
        end else if (!own_vld || (acc && cnt_nx == {1'b0, quota_q})) begin
            state_d = IDLE;
            ptr_d = owner_q + IW'(1);
        end else if (acc) begin
            cnt_d = cnt_nx;
        end
    end

    always_comb begin
        vld_d = acc || (vld_q && !bus.iRdy);
        pld_d = acc ? bus.iPld[sel*DW +: DW] : pld_q;
        dst_d = acc ? bus.iDst[sel*AW +: AW] : dst_q;
        src_d = acc ? sel : src_q;
    end

    assign bus.oRdy = rdy;
    assign bus.oVld = vld_q;
    assign bus.oPld = pld_q;
    assign bus.oDst = dst_q;
    assign bus.oSrc = src_q;
    assign bus.oBusy = state_q == LOCK;
endmodule

// File: tb/tb_dcp_rd_cmd_arb.sv
// tb_dcp_rd_cmd_arb: vector tables, corner sequences and randomized traffic against a beat-level model.
module tb_dcp_rd_cmd_arb;
    import dcp_arb_pkg::*;
    localparam int N = ARB_N, DW = CRSBAR_WIDTH, AW = ARB_AW, QW = ARB_QW;

    typedef struct {
        logic rst;
        logic [N-1:0] vld;
        logic rdy;
        logic [3:0] q2;
        logic [3:0] q5;
        logic exp_vld;
        logic [3:0] exp_src;
        logic exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcp_rd_cmd_arb_if #(.N(N), .DW(DW), .AW(AW), .QW(QW)) bus ();
    dcp_rd_cmd_arb #(.N(N), .DW(DW), .AW(AW), .QW(QW)) dut (.iClk(clk), .iRst(rst), .bus(bus));

    int checks = 0, errors = 0;
    logic m_vld = 1'b0;
    logic [DW-1:0] m_pld = '0;
    logic [AW-1:0] m_dst = '0;
    int m_src = 0, m_ptr = 0, m_owner = 0, m_left = 0;
    bit m_lock = 1'b0;
    int n_in[N], n_out[N];
    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string name, input logic v, input int src, input logic busy);
        chk({name, "_vld"}, 64'(bus.oVld), 64'(v));
        chk({name, "_src"}, 64'(bus.oSrc), 64'(src));
        chk({name, "_busy"}, 64'(bus.oBusy), 64'(busy));
    endtask

    task automatic setq_all(input int v);
        for (int k = 0; k < N; k++) bus.iQuota[k*QW +: QW] = QW'(v);
    endtask

    task automatic setq(input int k, input int v);
        bus.iQuota[k*QW +: QW] = QW'(v);
    endtask

    task automatic def_pld();
        for (int k = 0; k < N; k++) begin
            bus.iPld[k*DW +: DW] = DW'('h1A2 + k);
            bus.iDst[k*AW +: AW] = AW'(N - 1 - k);
        end
    endtask

    // Called one unit after a rising edge with inputs settled; compares mid-cycle, then advances the model.
    task automatic step();
        logic [N-1:0] er;
        logic ca;
        int w, q;
        #4;
        ca = !m_vld || bus.iRdy;
        w = -1;
        er = '0;
        if (!rst && ca) begin
            if (m_lock) w = bus.iVld[m_owner] ? m_owner : -1;
            else for (int i = 0; i < N; i++) if (w < 0 && bus.iVld[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        end
        if (w >= 0) er[w] = 1'b1;
        chk("oRdy", 64'(bus.oRdy), 64'(er));
        chk("oVld", 64'(bus.oVld), 64'(m_vld));
        chk("oPld", 64'(bus.oPld), 64'(m_pld));
        chk("oDst", 64'(bus.oDst), 64'(m_dst));
        chk("oSrc", 64'(bus.oSrc), 64'(m_src));
        chk("oBusy", 64'(bus.oBusy), 64'(m_lock));
        if (bus.oVld && bus.iRdy) n_out[bus.oSrc]++;
        if (rst) begin
            if (m_vld && !bus.iRdy) n_in[m_src]--;
            m_vld = 1'b0; m_pld = '0; m_dst = '0; m_src = 0;
            m_ptr = 0; m_owner = 0; m_left = 0; m_lock = 1'b0;
        end else begin
            if (w >= 0) begin
                n_in[w]++;
                m_vld = 1'b1;
                m_pld = bus.iPld[w*DW +: DW];
                m_dst = bus.iDst[w*AW +: AW];
                m_src = w;
            end else if (bus.iRdy) m_vld = 1'b0;
            if (m_lock) begin
                if (!bus.iVld[m_owner]) begin
                    m_lock = 1'b0;
                    m_ptr = (m_owner + 1) % N;
                end else if (w >= 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_lock = 1'b0;
                        m_ptr = (m_owner + 1) % N;
                    end
                end
            end else if (w >= 0) begin
                q = int'(bus.iQuota[w*QW +: QW]);
                if (q == 0) q = 1;
                m_owner = w;
                m_left = q - 1;
                if (m_left == 0) m_ptr = (w + 1) % N;
                else m_lock = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv.push_back('{1'b1, 16'h0000, 1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 1'b0});
        for (int i = 0; i < 17; i++) tv.push_back('{1'b0, 16'hFFFF, 1'b1, 4'd1, 4'd1, 1'b1, 4'(i % 16), 1'b0});
        tv.push_back('{1'b1, 16'h0024, 1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 1'b0});
        tv.push_back('{1'b0, 16'h0024, 1'b1, 4'd3, 4'd3, 1'b1, 4'd2, 1'b1});
        tv.push_back('{1'b0, 16'h0024, 1'b1, 4'd3, 4'd3, 1'b1, 4'd2, 1'b1});
        tv.push_back('{1'b0, 16'h0024, 1'b1, 4'd3, 4'd3, 1'b1, 4'd2, 1'b0});
        tv.push_back('{1'b0, 16'h0024, 1'b1, 4'd3, 4'd3, 1'b1, 4'd5, 1'b1});
        tv.push_back('{1'b0, 16'h0024, 1'b1, 4'd3, 4'd3, 1'b1, 4'd5, 1'b1});
        tv.push_back('{1'b0, 16'h0024, 1'b1, 4'd3, 4'd3, 1'b1, 4'd5, 1'b0});
        tv.push_back('{1'b0, 16'h0024, 1'b1, 4'd3, 4'd3, 1'b1, 4'd2, 1'b1});
        tv.push_back('{1'b1, 16'hFFFF, 1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 1'b0});
        tv.push_back('{1'b0, 16'hFFFF, 1'b1, 4'd1, 4'd1, 1'b1, 4'd0, 1'b0});
        tv.push_back('{1'b0, 16'hFFFF, 1'b1, 4'd1, 4'd1, 1'b1, 4'd1, 1'b0});
        for (int i = 0; i < 4; i++) tv.push_back('{1'b0, 16'hFFFF, 1'b0, 4'd1, 4'd1, 1'b1, 4'd1, 1'b0});
        tv.push_back('{1'b0, 16'hFFFF, 1'b1, 4'd1, 4'd1, 1'b1, 4'd2, 1'b0});
        tv.push_back('{1'b0, 16'hFFFF, 1'b1, 4'd1, 4'd1, 1'b1, 4'd3, 1'b0});

        bus.iVld = '1;
        bus.iRdy = 1'b1;
        setq_all(1);
        def_pld();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        step();
        expect_out("reset", 1'b0, 0, 1'b0);
        chk("reset_pld", 64'(bus.oPld), 64'(0));
        chk("reset_dst", 64'(bus.oDst), 64'(0));

        rst = 1'b0;
        bus.iVld = N'(1) << 3;
        step();
        expect_out("single", 1'b1, 3, 1'b0);
        chk("single_pld", 64'(bus.oPld), 64'h1A5);
        bus.iVld = (N'(1) << 2) | (N'(1) << 6);
        step();
        expect_out("ptr_adv", 1'b1, 6, 1'b0);

        foreach (tv[i]) begin
            rst = tv[i].rst;
            bus.iVld = tv[i].vld;
            bus.iRdy = tv[i].rdy;
            setq_all(1);
            setq(2, int'(tv[i].q2));
            setq(5, int'(tv[i].q5));
            step();
            expect_out($sformatf("tv%0d", i), tv[i].exp_vld, int'(tv[i].exp_src), tv[i].exp_busy);
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        setq_all(1);
        setq(7, 4);
        bus.iVld = (N'(1) << 7) | (N'(1) << 9);
        step();
        expect_out("gap_a", 1'b1, 7, 1'b1);
        step();
        expect_out("gap_b", 1'b1, 7, 1'b1);
        bus.iVld = N'(1) << 9;
        step();
        expect_out("gap_bubble", 1'b0, 7, 1'b0);
        step();
        expect_out("gap_next", 1'b1, 9, 1'b0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        setq_all(1);
        setq(5, 4);
        bus.iVld = N'(1) << 5;
        step();
        step();
        expect_out("lock5", 1'b1, 5, 1'b1);
        rst = 1'b1;
        bus.iVld = (N'(1) << 1) | (N'(1) << 3) | (N'(1) << 5);
        step();
        expect_out("rst_lock", 1'b0, 0, 1'b0);
        rst = 1'b0;
        step();
        expect_out("post_rst", 1'b1, 1, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) for (int k = 0; k < N; k++) setq(k, $urandom_range(0, 15));
            for (int k = 0; k < N; k++) begin
                bus.iPld[k*DW +: DW] = DW'({$urandom(), $urandom()});
                bus.iDst[k*AW +: AW] = AW'($urandom());
            end
            rst = $urandom_range(0, 199) == 0;
            bus.iVld = N'($urandom()) | N'($urandom());
            bus.iRdy = $urandom_range(0, 3) != 0;
            step();
        end

        rst = 1'b0;
        bus.iVld = '0;
        bus.iRdy = 1'b1;
        for (int c = 0; c < 3; c++) step();
        for (int k = 0; k < N; k++) chk($sformatf("count%0d", k), 64'(n_out[k]), 64'(n_in[k]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
